fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised operand-hazard and forwarding unit for the decode/issue boundary. It generalises the fixed two-operand, two-bypass forwarding done in decode.
- Adds a per-register in-flight write scoreboard, so that long-latency producers (mul/div, loads, TLB/CP0 reads) can stall consumers without a dedicated bypass.
- Supports N read operands, M prioritised bypass channels, K retire ports, a registered valid/ready output stage and a global flush.

Parameters:
- NUM_RD, 2, number of source operands per instruction.
- NUM_FWD, 3, number of bypass channels; index 0 is the youngest and has the highest priority.
- NUM_RET, 1, number of retire (register write-back) ports.
- CNT_W, 2, width of the per-register in-flight write counter; max = 2^CNT_W-1.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- flush  in  1  exception/eret commit; kills the issue in this cycle and clears the scoreboard.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  instruction accepted this cycle when in_valid is also high.
- rd_en  in  NUM_RD  operand i is actually read.
- rd_addr  in  NUM_RD*5  operand register numbers; operand i is at [5i+4:5i].
- rf_rdata  in  NUM_RD*32  register-file read data.
- in_waddr  in  5  destination register; 0 means no write.
- fwd_addr  in  NUM_FWD*5  bypass destination; 0 means the channel carries no write.
- fwd_data  in  NUM_FWD*32  bypass data.
- fwd_ok  in  NUM_FWD  bypass data is valid this cycle.
- ret_valid  in  NUM_RET  retire port k writes the register file this cycle.
- ret_addr  in  NUM_RET*5  register written by retire port k.
- out_valid  out  1  registered operand bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_rdata  out  NUM_RD*32  resolved operand data.
- busy_vec  out  32  bit r set when cnt[r] != 0.
- err_underflow  out  1  sticky: a retire arrived for a register whose count was 0.

Behaviour:
- State:
  - cnt[1..31], each CNT_W bits; cnt[0] is hard-wired to 0.
  - out_valid, out_rdata, err_underflow.
- Reset: all cnt = 0, out_valid = 0, out_rdata = 0, err_underflow = 0. busy_vec is therefore 0.
- Operand resolution, combinational, per operand i with rd_en[i] = 1 and rd_addr[i] != 0:
  - j = the lowest channel index with fwd_addr[j] == rd_addr[i].
  - If j exists and fwd_ok[j] = 1: data = fwd_data[j].
  - If j exists and fwd_ok[j] = 0: stall_i = 1. Older channels are not consulted.
  - If no channel hits and cnt[rd_addr[i]] != 0: stall_i = 1.
  - Otherwise: data = rf_rdata[i].
  - If rd_en[i] = 0 or rd_addr[i] = 0: stall_i = 0 and data = rf_rdata[i].
- Lookups use the pre-update cnt. A writer retiring in the same cycle must also be presented on a bypass channel with fwd_ok = 1, or the consumer stalls for one cycle.
- sat = in_waddr != 0 and cnt[in_waddr] == max.
- out_free = !out_valid || out_ready.
- in_ready = !flush && !(any stall_i) && !sat && out_free.
- accept = in_valid && in_ready.
- Counter update each cycle, for r != 0: cnt[r] <= cnt[r] + inc[r] - dec[r].
  - inc[r] = accept && in_waddr == r.
  - dec[r] = the number of k with ret_valid[k] && ret_addr[k] == r.
  - Issue and retire on the same register in the same cycle leave the count unchanged.
  - If dec[r] exceeds cnt[r] + inc[r]: the result clamps to 0 and err_underflow <= 1.
  - Retires to r0 are ignored.
- Flush has priority over every other update: all cnt <= 0, out_valid <= 0, and no accept happens. The pipeline guarantees that killed instructions never assert ret_valid after the flush.
- Output stage, latency 1:
  - If accept: out_valid <= 1 and out_rdata <= resolved data.
  - Else if out_ready: out_valid <= 0.
  - out_rdata holds its value while out_valid && !out_ready.
- No combinational path from out_ready to out_rdata.

Test Plan:
- Reset, then in_valid with rd_addr = {3,4}, cnt = 0, no bypass hits, rf_rdata = {0x11,0x22} -> in_ready = 1; next cycle out_valid = 1, out_rdata = {0x11,0x22}, busy_vec = 0.
- Issue waddr = 5; next instruction reads r5 with fwd_addr[1] = 5, fwd_ok[1] = 1, data 0xABCD -> no stall, operand = 0xABCD. With fwd_ok = 0 -> in_ready = 0 until ok rises. With fwd_addr[0] = 5 ok = 0 and fwd_addr[1] = 5 ok = 1 -> still stalls.
- Issue waddr = 7 (cnt 1) with no bypass hit, then read r7 -> stall until ret_valid with ret_addr = 7 plus a bypass ok. Issue and retire on r7 in the same cycle -> cnt stays 1.
- With CNT_W = 2, issue three writes to r9 -> cnt = 3; a fourth in_valid writing r9 -> in_ready = 0 until one retire.
- cnt[2] = 2, then flush with in_valid high -> no accept, all cnt = 0, out_valid = 0 next cycle. A ret_valid for r2 afterwards -> err_underflow = 1, cnt stays 0.
- out_ready = 0 with out_valid = 1 -> in_ready = 0 and out_rdata held. Release -> the bundle is consumed and a new accept is possible in the same cycle.

Source files
------------

// File: rtl/fwd_scoreboard_if.sv
// Issue/operand handshake bundle for fwd_scoreboard.
// master: decode side driving the instruction and consuming the bundle.
// slave:  the scoreboard itself.
interface fwd_scoreboard_if #(
  parameter int NUM_RD = 2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_RD-1:0]    rd_en;
  logic [NUM_RD*5-1:0]  rd_addr;
  logic [NUM_RD*32-1:0] rf_rdata;
  logic [4:0]           in_waddr;
  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_RD*32-1:0] out_rdata;

  modport master (
    output in_valid, rd_en, rd_addr, rf_rdata, in_waddr, out_ready,
    input  in_ready, out_valid, out_rdata
  );

  modport slave (
    input  in_valid, rd_en, rd_addr, rf_rdata, in_waddr, out_ready,
    output in_ready, out_valid, out_rdata
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand hazard / forwarding unit at the decode-issue boundary.
// Resolves NUM_RD operands against NUM_FWD prioritised bypass channels
// (channel 0 youngest), tracks in-flight writes per register with a
// saturating-at-issue counter, and registers the resolved operands.
module fwd_scoreboard #(
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 3,
  parameter int NUM_RET = 1,
  parameter int CNT_W   = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  fwd_scoreboard_if.slave       bus,
  input  logic [NUM_FWD*5-1:0]  fwd_addr,
  input  logic [NUM_FWD*32-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]    fwd_ok,
  input  logic [NUM_RET-1:0]    ret_valid,
  input  logic [NUM_RET*5-1:0]  ret_addr,
  output logic [31:0]           busy_vec,
  output logic                  err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // wide enough for cnt + 1 and for NUM_RET simultaneous retires
  localparam int SUM_W = CNT_W + $clog2(NUM_RET + 1) + 1;

  logic [CNT_W-1:0]     cnt     [32];
  logic [CNT_W-1:0]     cnt_nxt [32];
  logic [31:0]          uflow_vec;
  logic [NUM_RD-1:0]    stall;
  logic [NUM_RD*32-1:0] res_data;
  logic                 sat;
  logic                 out_free;
  logic                 ready;
  logic                 accept;

  // Operand resolution: the first matching channel decides, even when its
  // data is not ready yet; older channels hold stale values for that register.
  always_comb begin
    logic [4:0] a;
    logic       hit;
    a        = '0;
    hit      = 1'b0;
    stall    = '0;
    res_data = bus.rf_rdata;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      a   = bus.rd_addr[5*i +: 5];
      hit = 1'b0;
      if (bus.rd_en[i] && a != 5'd0) begin
        for (int unsigned j = 0; j < NUM_FWD; j++) begin
          if (!hit && fwd_addr[5*j +: 5] == a) begin
            hit = 1'b1;
            if (fwd_ok[j]) begin
              res_data[32*i +: 32] = fwd_data[32*j +: 32];
            end else begin
              stall[i] = 1'b1;
            end
          end
        end
        if (!hit && cnt[a] != '0) begin
          stall[i] = 1'b1;
        end
      end
    end
  end

  // Issue handshake: blocked by flush, operand hazards, a saturated
  // destination counter, or a held output bundle.
  always_comb begin
    sat          = (bus.in_waddr != 5'd0) && (cnt[bus.in_waddr] == CNT_MAX);
    out_free     = !bus.out_valid || bus.out_ready;
    ready        = !flush && (stall == '0) && !sat && out_free;
    accept       = bus.in_valid && ready;
    bus.in_ready = ready;
  end

  // Per-register next count: +1 on issue, -1 per retire, clamped at zero.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] dec;
    sum       = '0;
    dec       = '0;
    busy_vec  = '0;
    uflow_vec = '0;
    for (int unsigned r = 0; r < 32; r++) begin
      cnt_nxt[r] = '0;
    end
    for (int unsigned r = 1; r < 32; r++) begin
      sum = SUM_W'(cnt[r]) + SUM_W'(accept && (bus.in_waddr == 5'(r)));
      dec = '0;
      for (int unsigned k = 0; k < NUM_RET; k++) begin
        if (ret_valid[k] && ret_addr[5*k +: 5] == 5'(r)) begin
          dec = dec + SUM_W'(1);
        end
      end
      if (dec > sum) begin
        cnt_nxt[r]   = '0;
        uflow_vec[r] = 1'b1;
      end else begin
        cnt_nxt[r] = CNT_W'(sum - dec);
      end
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  // Scoreboard state; flush wipes all in-flight writes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned r = 0; r < 32; r++) begin
        cnt[r] <= '0;
      end
      err_underflow <= 1'b0;
    end else if (flush) begin
      for (int unsigned r = 0; r < 32; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < 32; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      if (uflow_vec != '0) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // Registered output stage; data only loads on accept, so out_ready has
  // no path into out_rdata.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.out_valid <= 1'b0;
      bus.out_rdata <= '0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_rdata <= res_data;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus a
// randomized run against a behavioural reference model.
module tb_fwd_scoreboard;
  localparam int NUM_RD  = 2;
  localparam int NUM_FWD = 3;
  localparam int NUM_RET = 1;
  localparam int CNT_W   = 2;
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic flush;
  logic [NUM_FWD*5-1:0]  fwd_addr;
  logic [NUM_FWD*32-1:0] fwd_data;
  logic [NUM_FWD-1:0]    fwd_ok;
  logic [NUM_RET-1:0]    ret_valid;
  logic [NUM_RET*5-1:0]  ret_addr;
  logic [31:0]           busy_vec;
  logic                  err_underflow;

  fwd_scoreboard_if #(.NUM_RD(NUM_RD)) bus ();

  fwd_scoreboard #(
    .NUM_RD (NUM_RD),
    .NUM_FWD(NUM_FWD),
    .NUM_RET(NUM_RET),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .bus          (bus),
    .fwd_addr     (fwd_addr),
    .fwd_data     (fwd_data),
    .fwd_ok       (fwd_ok),
    .ret_valid    (ret_valid),
    .ret_addr     (ret_addr),
    .busy_vec     (busy_vec),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int                   m_cnt [32];
  bit                   m_ov;
  logic [NUM_RD*32-1:0] m_rdata;
  bit                   m_err;

  // resolve one operand from the rules: first matching channel wins
  function automatic bit resolve(input int i, output logic [31:0] d);
    logic [4:0] a;
    a = bus.rd_addr[5*i +: 5];
    d = bus.rf_rdata[32*i +: 32];
    if (!bus.rd_en[i] || a == 5'd0) return 1'b0;
    for (int j = 0; j < NUM_FWD; j++) begin
      if (fwd_addr[5*j +: 5] == a) begin
        if (fwd_ok[j]) begin
          d = fwd_data[32*j +: 32];
          return 1'b0;
        end
        return 1'b1;
      end
    end
    return m_cnt[a] != 0;
  endfunction

  function automatic bit model_ready(output logic [NUM_RD*32-1:0] d);
    bit          st;
    logic [31:0] od;
    st = 1'b0;
    d  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (resolve(i, od)) st = 1'b1;
      d[32*i +: 32] = od;
    end
    if (flush || st) return 1'b0;
    if (bus.in_waddr != 5'd0 && m_cnt[bus.in_waddr] == MAXC) return 1'b0;
    return !m_ov || bus.out_ready;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  // advance one clock and update the model from the inputs seen at the edge
  task automatic tick();
    bit                   rdy;
    bit                   acc;
    logic [NUM_RD*32-1:0] d;
    logic [4:0]           a;
    #1;
    rdy = model_ready(d);
    acc = bus.in_valid && rdy;
    @(posedge clk);
    if (!resetn) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_ov = 0; m_rdata = '0; m_err = 0;
    end else if (flush) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_ov = 0;
    end else begin
      if (acc && bus.in_waddr != 5'd0) m_cnt[bus.in_waddr]++;
      for (int k = 0; k < NUM_RET; k++) begin
        a = ret_addr[5*k +: 5];
        if (ret_valid[k] && a != 5'd0) begin
          if (m_cnt[a] == 0) m_err = 1;
          else m_cnt[a]--;
        end
      end
      if (acc) begin
        m_ov = 1; m_rdata = d;
      end else if (bus.out_ready) begin
        m_ov = 0;
      end
    end
    #1;
  endtask

  task automatic idle();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.rf_rdata = '0;
    bus.in_waddr = '0;
    bus.out_ready = 1'b1;
    fwd_addr  = '0;
    fwd_data  = '0;
    fwd_ok    = '0;
    ret_valid = '0;
    ret_addr  = '0;
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_rdata !== '0) begin errors++; $display("FAIL reset_out_rdata got=%h exp=0", bus.out_rdata); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    idle();
    bus.in_valid = 1'b1;
    bus.rd_en    = 2'b11;
    bus.rd_addr  = {5'd4, 5'd3};
    bus.rf_rdata = {32'h22, 32'h11};
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_rdata !== {32'h22, 32'h11}) begin errors++; $display("FAIL basic_out_rdata got=%h exp=%h", bus.out_rdata, {32'h22, 32'h11}); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL basic_busy got=%h exp=0", busy_vec); end
  endtask

  task automatic test_forward();
    idle();
    bus.in_valid = 1'b1;
    bus.in_waddr = 5'd5;
    tick();
    checks++; if (busy_vec !== 32'h20) begin errors++; $display("FAIL fwd_busy5 got=%h exp=00000020", busy_vec); end
    bus.in_waddr = 5'd0;
    bus.rd_en    = 2'b01;
    bus.rd_addr  = {5'd0, 5'd5};
    bus.rf_rdata = {32'h0, 32'hDEAD};
    fwd_addr     = {5'd0, 5'd5, 5'd0};
    fwd_data     = {32'h0, 32'hABCD, 32'h0};
    fwd_ok       = 3'b010;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fwd_hit_ready got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if (bus.out_rdata[31:0] !== 32'hABCD) begin errors++; $display("FAIL fwd_hit_data got=%h exp=0000abcd", bus.out_rdata[31:0]); end
    fwd_ok = 3'b000;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fwd_notok_ready got=%b exp=0", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fwd_stall_out_valid got=%b exp=0", bus.out_valid); end
    fwd_ok = 3'b010;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fwd_okrise_ready got=%b exp=1", bus.in_ready); end
    fwd_addr = {5'd0, 5'd5, 5'd5};
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL fwd_prio_ready got=%b exp=0", bus.in_ready); end
    tick();
    idle();
    ret_valid = 1'b1;
    ret_addr  = 5'd5;
    tick();
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL fwd_retire_busy got=%h exp=0", busy_vec); end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.in_valid = 1'b1;
    bus.in_waddr = 5'd7;
    tick();
    bus.in_waddr = 5'd0;
    bus.rd_en    = 2'b01;
    bus.rd_addr  = {5'd0, 5'd7};
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sb_stall1 got=%b exp=0", bus.in_ready); end
    tick();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sb_stall2 got=%b exp=0", bus.in_ready); end
    ret_valid = 1'b1;
    ret_addr  = 5'd7;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sb_ret_nofwd got=%b exp=0", bus.in_ready); end
    fwd_addr     = {5'd7, 5'd0, 5'd0};
    fwd_data     = {32'h77, 32'h0, 32'h0};
    fwd_ok       = 3'b100;
    bus.in_waddr = 5'd7;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sb_ret_fwd got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if (bus.out_rdata[31:0] !== 32'h77) begin errors++; $display("FAIL sb_fwd_data got=%h exp=00000077", bus.out_rdata[31:0]); end
    checks++; if (busy_vec !== 32'h80) begin errors++; $display("FAIL sb_same_cycle_busy got=%h exp=00000080", busy_vec); end
    idle();
    ret_valid = 1'b1;
    ret_addr  = 5'd7;
    tick();
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL sb_drain_busy got=%h exp=0", busy_vec); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL sb_err got=%b exp=0", err_underflow); end
  endtask

  task automatic test_saturation();
    idle();
    bus.in_valid = 1'b1;
    bus.in_waddr = 5'd9;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sat_fill%0d got=%b exp=1", n, bus.in_ready); end
      tick();
    end
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sat_full got=%b exp=0", bus.in_ready); end
    tick();
    ret_valid = 1'b1;
    ret_addr  = 5'd9;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sat_pre_update got=%b exp=0", bus.in_ready); end
    tick();
    ret_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL sat_after_ret got=%b exp=1", bus.in_ready); end
    tick();
    idle();
    ret_valid = 1'b1;
    ret_addr  = 5'd9;
    tick();
    tick();
    checks++; if (busy_vec !== 32'h200) begin errors++; $display("FAIL sat_one_left got=%h exp=00000200", busy_vec); end
    tick();
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL sat_drain got=%h exp=0", busy_vec); end
    checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL sat_err got=%b exp=0", err_underflow); end
  endtask

  task automatic test_flush_underflow();
    idle();
    bus.in_valid = 1'b1;
    bus.in_waddr = 5'd2;
    tick();
    tick();
    checks++; if (busy_vec !== 32'h4) begin errors++; $display("FAIL flush_pre_busy got=%h exp=00000004", busy_vec); end
    bus.out_ready = 1'b0;
    flush = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL flush_busy got=%h exp=0", busy_vec); end
    idle();
    ret_valid = 1'b1;
    ret_addr  = 5'd2;
    tick();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uflow_err got=%b exp=1", err_underflow); end
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL uflow_busy got=%h exp=0", busy_vec); end
    ret_valid = 1'b0;
    tick();
    checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uflow_sticky got=%b exp=1", err_underflow); end
  endtask

  task automatic test_backpressure();
    logic [63:0] da;
    logic [63:0] db;
    da = {$urandom, $urandom};
    db = {$urandom, $urandom};
    idle();
    bus.in_valid = 1'b1;
    bus.rd_en    = 2'b11;
    bus.rd_addr  = {5'd1, 5'd2};
    bus.rf_rdata = da;
    tick();
    checks++; if (bus.out_rdata !== da) begin errors++; $display("FAIL bp_first got=%h exp=%h", bus.out_rdata, da); end
    bus.out_ready = 1'b0;
    bus.rf_rdata  = db;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got=%b exp=0", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_rdata !== da) begin errors++; $display("FAIL bp_hold_data got=%h exp=%h", bus.out_rdata, da); end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
    tick();
    checks++; if (bus.out_rdata !== db) begin errors++; $display("FAIL bp_second got=%h exp=%h", bus.out_rdata, db); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got=%b exp=1", bus.out_valid); end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
  endtask

  task automatic test_random();
    logic [NUM_RD*32-1:0] d;
    bit                   er;
    int                   r;
    idle();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    for (int n = 0; n < 800; n++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.rd_en    = NUM_RD'($urandom);
      for (int i = 0; i < NUM_RD; i++) begin
        bus.rd_addr[5*i +: 5]   = 5'($urandom_range(0, 7));
        bus.rf_rdata[32*i +: 32] = $urandom;
      end
      bus.in_waddr = 5'($urandom_range(0, 7));
      for (int j = 0; j < NUM_FWD; j++) begin
        fwd_addr[5*j +: 5]   = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 7)) : 5'd0;
        fwd_ok[j]            = 1'($urandom);
        fwd_data[32*j +: 32] = $urandom;
      end
      r = $urandom_range(1, 7);
      ret_addr  = 5'(r);
      ret_valid = ((m_cnt[r] > 0) && ($urandom_range(0, 1) == 1)) || ($urandom_range(0, 60) == 0);
      flush     = ($urandom_range(0, 50) == 0);
      if (flush) ret_valid = 1'b0;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      er = model_ready(d);
      checks++; if (bus.in_ready !== er) begin errors++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, bus.in_ready, er); end
      tick();
      checks++; if (bus.out_valid !== m_ov) begin errors++; $display("FAIL rnd_out_valid[%0d] got=%b exp=%b", n, bus.out_valid, m_ov); end
      if (m_ov) begin
        checks++; if (bus.out_rdata !== m_rdata) begin errors++; $display("FAIL rnd_out_rdata[%0d] got=%h exp=%h", n, bus.out_rdata, m_rdata); end
      end
      checks++; if (busy_vec !== model_busy()) begin errors++; $display("FAIL rnd_busy[%0d] got=%h exp=%h", n, busy_vec, model_busy()); end
      checks++; if (err_underflow !== m_err) begin errors++; $display("FAIL rnd_err[%0d] got=%b exp=%b", n, err_underflow, m_err); end
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_ov = 0; m_rdata = '0; m_err = 0;
    test_reset();
    test_basic();
    test_forward();
    test_scoreboard();
    test_saturation();
    test_flush_underflow();
    test_backpressure();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
